// File: rtl/sum_uart_reporter.sv
// sum_uart_reporter: latches two operands on active-low strobes, keeps their
// registered sum, and reports that sum over a UART as an uppercase hex line
// ("HH..\r\n", 8N1). Requests that arrive while a frame is on the wire are
// merged into one follow-up frame, which carries the sum current at its LOAD.
//
// Handshake: there is no valid/ready pair. A capture event is a one-cycle
// falling edge of a synchronized strobe. With uart_tx_en=1 it sets a sticky
// pending flag. The serializer consumes pending in LOAD.
module sum_uart_reporter #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              save_a_n,
  input  logic              save_b_n,
  input  logic [DATA_W-1:0] data_input,
  input  logic              uart_tx_en,
  output logic              uart_txd,
  output logic              uart_tx_busy,
  output logic [DATA_W:0]   sum
);

  localparam int NDIG = (DATA_W + 1 + 3) / 4;
  localparam int PADW = NDIG * 4;
  localparam int BW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW   = $clog2(NDIG + 2);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CHAR_CR   = CW'(NDIG);
  localparam logic [CW-1:0] CHAR_LAST = CW'(NDIG + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;

  // ASCII code for character idx of a frame carrying val.
  function automatic logic [7:0] char_at(input logic [CW-1:0] idx,
                                         input logic [DATA_W:0] val);
    logic [PADW-1:0] pad;
    logic [3:0]      nib;
    int              sh;
    pad = PADW'(val);
    sh  = 0;
    nib = 4'h0;
    if (idx == CHAR_CR) begin
      char_at = 8'h0D;
    end else if (idx == CHAR_LAST) begin
      char_at = 8'h0A;
    end else begin
      sh  = 4 * (NDIG - 1 - int'(idx));
      nib = 4'(pad >> sh);
      char_at = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    end
  endfunction

  logic              r_a_s1, r_a_s2, r_a_hist;
  logic              r_b_s1, r_b_s2, r_b_hist;
  logic [DATA_W-1:0] r_a, r_b;
  logic [DATA_W:0]   r_sum;
  logic [DATA_W:0]   r_frame;
  logic              r_pending;
  state_t            r_state, w_state_next;
  logic [BW-1:0]     r_baud_cnt;
  logic [2:0]        r_bit_idx;
  logic [CW-1:0]     r_char_idx;
  logic [7:0]        r_shift;

  logic              w_a_evt, w_b_evt, w_baud_done;
  logic [CW-1:0]     w_char_next;

  assign w_a_evt     = r_a_hist & ~r_a_s2;
  assign w_b_evt     = r_b_hist & ~r_b_s2;
  assign w_baud_done = (r_baud_cnt == BAUD_LAST);
  assign w_char_next = r_char_idx + CW'(1);
  assign sum         = r_sum;

  // Two-flop synchronizers plus history flop; reset high so release is quiet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_s1 <= 1'b1; r_a_s2 <= 1'b1; r_a_hist <= 1'b1;
      r_b_s1 <= 1'b1; r_b_s2 <= 1'b1; r_b_hist <= 1'b1;
    end else begin
      r_a_s1 <= save_a_n; r_a_s2 <= r_a_s1; r_a_hist <= r_a_s2;
      r_b_s1 <= save_b_n; r_b_s2 <= r_b_s1; r_b_hist <= r_b_s2;
    end
  end

  // Operand capture and registered full-carry sum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sum <= '0;
    end else begin
      if (w_a_evt) r_a <= data_input;
      if (w_b_evt) r_b <= data_input;
      r_sum <= {1'b0, r_a} + {1'b0, r_b};
    end
  end

  // Sticky frame request; a capture in the LOAD cycle wins over the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 1'b0;
    end else if (!uart_tx_en) begin
      r_pending <= 1'b0;
    end else if (w_a_evt || w_b_evt) begin
      r_pending <= 1'b1;
    end else if (r_state == S_LOAD) begin
      r_pending <= 1'b0;
    end
  end

  // Serializer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Serializer next-state and line outputs.
  always_comb begin
    w_state_next = r_state;
    uart_txd     = 1'b1;
    uart_tx_busy = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_pending) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        w_state_next = S_START;
      end
      S_START: begin
        uart_txd     = 1'b0;
        uart_tx_busy = 1'b1;
        if (w_baud_done) w_state_next = S_DATA;
      end
      S_DATA: begin
        uart_txd     = r_shift[0];
        uart_tx_busy = 1'b1;
        if (w_baud_done && (r_bit_idx == 3'd7)) w_state_next = S_STOP;
      end
      S_STOP: begin
        uart_tx_busy = 1'b1;
        if (w_baud_done) begin
          w_state_next = (r_char_idx == CHAR_LAST) ? S_IDLE : S_START;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Bit timing, bit/char counters, snapshot and character shift register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_char_idx <= '0;
      r_shift    <= 8'hFF;
      r_frame    <= '0;
    end else begin
      unique case (r_state)
        S_LOAD: begin
          r_frame    <= r_sum;
          r_char_idx <= '0;
          r_shift    <= char_at('0, r_sum);
          r_baud_cnt <= '0;
          r_bit_idx  <= '0;
        end
        S_START: begin
          r_baud_cnt <= w_baud_done ? '0 : r_baud_cnt + BW'(1);
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= r_bit_idx + 3'd1;
            r_shift    <= {1'b0, r_shift[7:1]};
          end else begin
            r_baud_cnt <= r_baud_cnt + BW'(1);
          end
        end
        S_STOP: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            if (r_char_idx != CHAR_LAST) begin
              r_char_idx <= w_char_next;
              r_shift    <= char_at(w_char_next, r_frame);
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + BW'(1);
          end
        end
        default: begin
          r_baud_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_uart_reporter.sv
// Bench for sum_uart_reporter: random and directed operand captures, a
// UART receiver that checks every decoded byte against an expected queue,
// and a busy-width monitor.
module tb_sum_uart_reporter;

  localparam int DW         = 4;
  localparam int CPB        = 4;
  localparam int NDIG       = 2;
  localparam int FRAME_CLKS = (NDIG + 2) * 10 * CPB;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          save_a_n = 1'b1;
  logic          save_b_n = 1'b1;
  logic [DW-1:0] data_input = '0;
  logic          uart_tx_en = 1'b1;
  logic          uart_txd;
  logic          uart_tx_busy;
  logic [DW:0]   sum;

  always #5 clk = ~clk;

  sum_uart_reporter #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .save_a_n     (save_a_n),
    .save_b_n     (save_b_n),
    .data_input   (data_input),
    .uart_tx_en   (uart_tx_en),
    .uart_txd     (uart_txd),
    .uart_tx_busy (uart_tx_busy),
    .sum          (sum)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         frames_done = 0;
  int         ma = 0;
  int         mb = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected line for a sum: uppercase hex digits, MSB first, then CR LF.
  task automatic push_frame(input int s);
    for (int k = NDIG - 1; k >= 0; k--) begin
      int nib;
      nib = (s >> (4 * k)) & 15;
      exp_q.push_back((nib < 10) ? 8'(48 + nib) : 8'(55 + nib));
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic capture(input bit da, input bit db, input logic [DW-1:0] d);
    @(negedge clk);
    data_input = d;
    save_a_n   = !da;
    save_b_n   = !db;
    repeat ($urandom_range(1, 5)) @(negedge clk);
    save_a_n = 1'b1;
    save_b_n = 1'b1;
    repeat (4) @(negedge clk);
    if (da) ma = int'(d);
    if (db) mb = int'(d);
  endtask

  task automatic check_sum(input string name);
    @(negedge clk);
    check(name, int'(sum), ma + mb);
  endtask

  task automatic wait_busy_rise(input string name);
    int t;
    t = 0;
    while (!uart_tx_busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    check(name, int'(uart_tx_busy), 1);
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || uart_tx_busy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  // UART receiver: mid-bit sampling; bytes overlapping a reset are dropped.
  initial begin
    logic [7:0] b;
    logic       st, sp;
    bit         saw_rst;
    forever begin
      @(negedge uart_txd);
      if (reset_n) begin
        saw_rst = 1'b0;
        b = 8'h00;
        repeat (CPB / 2) @(negedge clk);
        st = uart_txd;
        saw_rst = saw_rst | !reset_n;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_txd;
          saw_rst = saw_rst | !reset_n;
        end
        repeat (CPB) @(negedge clk);
        sp = uart_txd;
        saw_rst = saw_rst | !reset_n;
        if (!saw_rst) begin
          check("start_bit", int'(st), 0);
          check("stop_bit", int'(sp), 1);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_byte: got 0x%02h expected none", b);
          end else begin
            check("rx_byte", int'(b), int'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  // Busy pulse width per completed frame.
  initial begin
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        run = 0;
      end else if (uart_tx_busy) begin
        run++;
      end else if (run > 0) begin
        check("busy_width", run, FRAME_CLKS);
        frames_done++;
        run = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f0, ops, cnt, s;
    logic [DW-1:0] d;

    // Clock/reset
    #3 reset_n = 1'b0;
    #1;
    check("reset_sum", int'(sum), 0);
    check("reset_txd", int'(uart_txd), 1);
    check("reset_busy", int'(uart_tx_busy), 0);
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // A=9 then B=8: "09" then "11" (second coalesced behind the first)
    f0 = frames_done;
    capture(1'b1, 1'b0, 4'd9);
    push_frame(ma + mb);
    check_sum("t1_sum_a");
    capture(1'b0, 1'b1, 4'd8);
    push_frame(ma + mb);
    check_sum("t1_sum");
    wait_drain("t1_drain");
    check("t1_frames", frames_done - f0, 2);

    // A=F, B=F: carry kept, uppercase alpha digit
    f0 = frames_done;
    capture(1'b1, 1'b0, 4'hF);
    push_frame(ma + mb);
    capture(1'b0, 1'b1, 4'hF);
    push_frame(ma + mb);
    check_sum("t2_sum");
    wait_drain("t2_drain");
    check("t2_frames", frames_done - f0, 2);

    // Simultaneous strobes: one frame
    f0 = frames_done;
    capture(1'b1, 1'b1, 4'd5);
    push_frame(ma + mb);
    check_sum("t3_sum");
    wait_drain("t3_drain");
    check("t3_frames", frames_done - f0, 1);

    // Three mid-frame captures collapse into one follow-up frame
    f0 = frames_done;
    capture(1'b1, 1'b0, 4'd0);
    push_frame(ma + mb);
    wait_busy_rise("t4_busy");
    capture(1'b1, 1'b0, 4'd1);
    capture(1'b0, 1'b1, 4'd2);
    capture(1'b1, 1'b0, 4'd3);
    push_frame(ma + mb);
    check_sum("t4_sum");
    wait_drain("t4_drain");
    check("t4_frames", frames_done - f0, 2);
    repeat (400) @(negedge clk);
    check("t4_no_third", frames_done - f0, 2);

    // Randomized captures with random mid-frame bursts
    for (int it = 0; it < 8; it++) begin
      f0 = frames_done;
      s = $urandom_range(0, 2);
      d = DW'($urandom_range(0, 15));
      capture(s != 1, s != 0, d);
      push_frame(ma + mb);
      wait_busy_rise("rnd_busy");
      ops = $urandom_range(0, 3);
      for (int k = 0; k < ops; k++) begin
        s = $urandom_range(0, 2);
        d = DW'($urandom_range(0, 15));
        capture(s != 1, s != 0, d);
      end
      if (ops > 0) push_frame(ma + mb);
      check_sum("rnd_sum");
      wait_drain("rnd_drain");
      check("rnd_frames", frames_done - f0, (ops > 0) ? 2 : 1);
    end

    // Reset in the middle of the data bits abandons the frame
    capture(1'b1, 1'b0, DW'($urandom_range(1, 15)));
    wait_busy_rise("t6_busy");
    repeat (20) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t6_txd", int'(uart_txd), 1);
    check("t6_busy_low", int'(uart_tx_busy), 0);
    check("t6_sum", int'(sum), 0);
    ma = 0;
    mb = 0;
    exp_q.delete();
    repeat (6) @(negedge clk);
    #2 reset_n = 1'b1;
    f0 = frames_done;
    cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (uart_tx_busy || !uart_txd) cnt++;
    end
    check("t6_quiet", cnt, 0);
    check("t6_frames", frames_done - f0, 0);
    check_sum("t6_sum_after");

    // uart_tx_en=0: silent update
    uart_tx_en = 1'b0;
    capture(1'b1, 1'b0, 4'd7);
    check_sum("t5_sum");
    cnt = 0;
    repeat (500) begin
      @(negedge clk);
      if (uart_tx_busy || !uart_txd) cnt++;
    end
    check("t5_silent", cnt, 0);
    uart_tx_en = 1'b1;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (uart_tx_busy) cnt++;
    end
    check("t5_no_late_frame", cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
